// File: rtl/tm1637_byte_tx.sv
// TM1637 byte transmitter: optional start, eight data bits LSB-first, ACK clock, optional stop.
// One request per byte; completion and the sampled ACK level are reported back to the sequencer.
module tm1637_byte_tx #(
  parameter int unsigned CLK_DIV = 100,
  parameter int unsigned CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_start_i,
  input  logic       tx_stop_i,
  output logic       ready_o,
  output logic       done_o,
  output logic       ack_err_o,
  output logic       tm1637_clk_o,
  output logic       tm1637_dio_oe_o,
  input  logic       tm1637_dio_in_i
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START0, S_START1, S_BIT_LOW, S_BIT_HIGH,
    S_ACK_LOW, S_ACK_HIGH, S_STOP0, S_STOP1, S_STOP2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       mask_q, mask_d;
  logic             stop_q, stop_d;
  logic             in_txn_q, in_txn_d;
  logic             ack_smp_q, ack_smp_d;
  logic             sync1_q, sync2_q;
  logic             scl_q, scl_d;
  logic             oe_q, oe_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic             phase_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      stop_q    <= 1'b0;
      in_txn_q  <= 1'b0;
      ack_smp_q <= 1'b1;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      scl_q     <= 1'b1;
      oe_q      <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      stop_q    <= stop_d;
      in_txn_q  <= in_txn_d;
      ack_smp_q <= ack_smp_d;
      sync1_q   <= tm1637_dio_in_i;
      sync2_q   <= sync1_q;
      scl_q     <= scl_d;
      oe_q      <= oe_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    mask_d    = mask_q;
    stop_d    = stop_q;
    in_txn_d  = in_txn_q;
    ack_smp_d = ack_smp_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;
    phase_end = (cnt_q == CNT_LAST);

    // Every bus phase lasts CLK_DIV cycles; the counter restarts on each state change.
    if (state_q != S_IDLE) begin
      cnt_d = phase_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (wr_i) begin
          data_d  = tx_data_i;
          stop_d  = tx_stop_i;
          mask_d  = 8'h80;
          cnt_d   = '0;
          state_d = (tx_start_i || !in_txn_q) ? S_START0 : S_BIT_LOW;
        end
      end
      S_START0: if (phase_end) state_d = S_START1;
      S_START1: begin
        in_txn_d = 1'b1;
        if (phase_end) state_d = S_BIT_LOW;
      end
      S_BIT_LOW: if (phase_end) state_d = S_BIT_HIGH;
      S_BIT_HIGH: begin
        // data shifts right so bit 0 is always the one on the wire; mask marks the last bit
        if (phase_end) begin
          if (mask_q[0]) begin
            state_d = S_ACK_LOW;
          end else begin
            data_d  = {1'b0, data_q[7:1]};
            mask_d  = {1'b0, mask_q[7:1]};
            state_d = S_BIT_LOW;
          end
        end
      end
      S_ACK_LOW: if (phase_end) state_d = S_ACK_HIGH;
      S_ACK_HIGH: begin
        if (phase_end) begin
          ack_smp_d = sync2_q;
          if (stop_q) begin
            state_d = S_STOP0;
          end else begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            ack_err_d = sync2_q;
          end
        end
      end
      S_STOP0: if (phase_end) state_d = S_STOP1;
      S_STOP1: if (phase_end) state_d = S_STOP2;
      S_STOP2: begin
        if (phase_end) begin
          in_txn_d  = 1'b0;
          state_d   = S_IDLE;
          done_d    = 1'b1;
          ack_err_d = ack_smp_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bus levels follow the upcoming state so they register together with it.
    scl_d   = 1'b1;
    oe_d    = 1'b0;
    ready_d = (state_d == S_IDLE);
    case (state_d)
      S_START1:   oe_d = 1'b1;
      S_BIT_LOW: begin
        scl_d = 1'b0;
        oe_d  = ~data_d[0];
      end
      S_BIT_HIGH: oe_d = ~data_d[0];
      S_ACK_LOW:  scl_d = 1'b0;
      S_STOP0: begin
        scl_d = 1'b0;
        oe_d  = 1'b1;
      end
      S_STOP1:    oe_d = 1'b1;
      default: begin
        scl_d = 1'b1;
        oe_d  = 1'b0;
      end
    endcase
  end

  assign ready_o         = ready_q;
  assign done_o          = done_q;
  assign ack_err_o       = ack_err_q;
  assign tm1637_clk_o    = scl_q;
  assign tm1637_dio_oe_o = oe_q;

endmodule

// File: tb/tb_tm1637_byte_tx.sv
// Bench for tm1637_byte_tx: a per-cycle bus waveform model built from phase lists,
// checked every cycle, plus directed transfers with hand-computed latencies and bit patterns.
module tb_tm1637_byte_tx;

  localparam int unsigned K = 4;

  typedef struct packed {
    logic scl;
    logic oe;
    logic rdy;
    logic dn;
    logic ack;
    logic aw;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_stop = 1'b0;
  logic       ready, done, ack_err, bus_clk, bus_oe;
  logic       slave_pull = 1'b0;
  logic       dio_pin;

  assign dio_pin = ~(bus_oe | slave_pull);

  always #5 clk = ~clk;

  tm1637_byte_tx #(.CLK_DIV(K), .CNT_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_i            (wr),
    .tx_data_i       (tx_data),
    .tx_start_i      (tx_start),
    .tx_stop_i       (tx_stop),
    .ready_o         (ready),
    .done_o          (done),
    .ack_err_o       (ack_err),
    .tm1637_clk_o    (bus_clk),
    .tm1637_dio_oe_o (bus_oe),
    .tm1637_dio_in_i (dio_pin)
  );

  exp_t       q[$];
  exp_t       cur;
  bit         in_txn_m = 1'b0;
  bit         ack_mode = 1'b1;
  bit         started = 1'b0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         start_cnt = 0;
  int         stop_cnt = 0;
  int         n_bits = 0;
  logic [7:0] bits_seen = 8'h00;
  logic       prev_scl = 1'b1;
  logic       prev_oe = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_phase(input logic scl, input logic oe, input logic aw);
    exp_t e;
    e.scl = scl; e.oe = oe; e.rdy = 1'b0; e.dn = 1'b0; e.ack = cur.ack; e.aw = aw;
    repeat (K) q.push_back(e);
  endtask

  // Expected bus waveform of one request, one entry per clock cycle.
  task automatic build(input logic [7:0] d, input logic s, input logic p);
    exp_t e;
    if (s || !in_txn_m) begin
      push_phase(1'b1, 1'b0, 1'b0);
      push_phase(1'b1, 1'b1, 1'b0);
      in_txn_m = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      push_phase(1'b0, ~d[i], 1'b0);
      push_phase(1'b1, ~d[i], 1'b0);
    end
    push_phase(1'b0, 1'b0, 1'b1);
    push_phase(1'b1, 1'b0, 1'b1);
    if (p) begin
      push_phase(1'b0, 1'b1, 1'b0);
      push_phase(1'b1, 1'b1, 1'b0);
      push_phase(1'b1, 1'b0, 1'b0);
      in_txn_m = 1'b0;
    end
    e.scl = 1'b1; e.oe = 1'b0; e.rdy = 1'b1; e.dn = 1'b1; e.ack = ~ack_mode; e.aw = 1'b0;
    q.push_back(e);
  endtask

  // Model: advance one entry per clock; accept a request whenever the model is idle.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      q.delete();
      cur.scl = 1'b1; cur.oe = 1'b0; cur.rdy = 1'b1; cur.dn = 1'b0; cur.ack = 1'b0; cur.aw = 1'b0;
      in_txn_m = 1'b0;
      started  = 1'b1;
    end else begin
      if (cur.rdy && wr) build(tx_data, tx_start, tx_stop);
      if (q.size() > 0) begin
        cur = q.pop_front();
      end else begin
        cur.rdy = 1'b1; cur.dn = 1'b0; cur.aw = 1'b0;
      end
    end
  end

  // Compare DUT against the model on every cycle; also log bus events for the directed checks.
  always @(negedge clk) begin
    if (started) begin
      chk("tm1637_clk", bus_clk, cur.scl);
      chk("dio_oe", bus_oe, cur.oe);
      chk("ready", ready, cur.rdy);
      chk("done", done, cur.dn);
      chk("ack_err", ack_err, cur.ack);
      slave_pull = ack_mode & cur.aw;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_scl && bus_clk && !prev_oe && bus_oe) start_cnt++;
      if (prev_scl && bus_clk && prev_oe && !bus_oe) stop_cnt++;
      if (!prev_scl && bus_clk && n_bits < 8) begin
        bits_seen[n_bits] = ~bus_oe;
        n_bits++;
      end
      prev_scl = bus_clk;
      prev_oe  = bus_oe;
    end
  end

  task automatic clear_events();
    start_cnt = 0; stop_cnt = 0; n_bits = 0; bits_seen = 8'h00;
  endtask

  task automatic run_txn(input logic [7:0] d, input logic s, input logic p,
                         input int exp_delta, input string nm);
    int w, base;
    tx_data = d; tx_start = s; tx_stop = p; wr = 1'b1;
    w = cyc; base = done_cnt;
    @(posedge clk); #2;
    wr = 1'b0; tx_data = 8'($urandom); tx_start = 1'($urandom); tx_stop = 1'($urandom);
    for (int i = 0; i < 400 && done_cnt == base; i++) begin
      @(negedge clk); #1;
    end
    if (done_cnt == base) begin
      n_chk++; n_fail++;
      $display("FAIL %s: no done within 400 cycles", nm);
    end else begin
      chk({nm, " latency"}, 32'(done_cyc - w), 32'(exp_delta));
    end
  endtask

  task automatic chk_bits(input logic [7:0] v, input string nm);
    chk({nm, " bit count"}, 32'(n_bits), 32'd8);
    for (int i = 0; i < 8; i++) chk({nm, " dio bit"}, 32'(bits_seen[i]), 32'(v[i]));
  endtask

  initial begin
    int base, w;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("reset ready", ready, 1'b1);
    chk("reset clk", bus_clk, 1'b1);
    chk("reset oe", bus_oe, 1'b0);
    chk("reset ack_err", ack_err, 1'b0);

    // 0x40 with start/stop, slave acknowledges: 23 phases -> done 93 cycles after wr
    @(posedge clk); #2;
    ack_mode = 1'b1; clear_events();
    run_txn(8'h40, 1'b1, 1'b1, 93, "t1");
    chk_bits(8'b0100_0000, "t1");
    chk("t1 starts", 32'(start_cnt), 32'd1);
    chk("t1 stops", 32'(stop_cnt), 32'd1);
    chk("t1 ack_err", ack_err, 1'b0);

    // same byte, nobody acknowledges
    ack_mode = 1'b0; clear_events();
    run_txn(8'h40, 1'b1, 1'b1, 93, "t2");
    chk("t2 ack_err", ack_err, 1'b1);
    chk("t2 stops", 32'(stop_cnt), 32'd1);
    chk("t2 end clk", bus_clk, 1'b1);
    chk("t2 end oe", bus_oe, 1'b0);

    // burst issued on each done cycle: 20, 18, 21 phases
    ack_mode = 1'b1; clear_events(); base = done_cnt;
    run_txn(8'hC0, 1'b1, 1'b0, 81, "t3a");
    chk_bits(8'b1100_0000, "t3a");
    chk("t3a ack_err", ack_err, 1'b0);
    run_txn(8'h3F, 1'b0, 1'b0, 73, "t3b");
    run_txn(8'h06, 1'b0, 1'b1, 85, "t3c");
    chk("t3 starts", 32'(start_cnt), 32'd1);
    chk("t3 stops", 32'(stop_cnt), 32'd1);
    chk("t3 dones", 32'(done_cnt - base), 32'd3);

    // bus idle after stop: tx_start=0 still gets a start
    clear_events();
    run_txn(8'h12, 1'b0, 1'b0, 81, "t4");
    chk("t4 starts", 32'(start_cnt), 32'd1);
    chk("t4 stops", 32'(stop_cnt), 32'd0);

    // reset part-way through a transfer
    base = done_cnt;
    tx_data = 8'hA5; tx_start = 1'b1; tx_stop = 1'b1; wr = 1'b1;
    @(posedge clk); #2 wr = 1'b0;
    repeat (29) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("t5 clk", bus_clk, 1'b1);
    chk("t5 oe", bus_oe, 1'b0);
    chk("t5 ready", ready, 1'b1);
    chk("t5 done", done, 1'b0);
    repeat (120) @(posedge clk);
    #2 chk("t5 no done", 32'(done_cnt - base), 32'd0);

    // wr held every cycle while busy with changing inputs
    clear_events(); base = done_cnt;
    tx_data = 8'h5A; tx_start = 1'b1; tx_stop = 1'b0; wr = 1'b1; w = cyc;
    repeat (80) begin
      @(posedge clk); #2;
      tx_data = 8'($urandom); tx_start = 1'($urandom); tx_stop = 1'($urandom);
    end
    wr = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("t6 dones", 32'(done_cnt - base), 32'd1);
    chk("t6 latency", 32'(done_cyc - w), 32'd81);
    chk_bits(8'b0101_1010, "t6");
    chk("t6 stops", 32'(stop_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
